// File: rtl/apb_irq_arbiter_pkg.sv
// Shared types and constants for the interrupt arbiter slice.
// Optional feature macro used by this slice: IRQ_ARB_ROUND_ROBIN_EN
package irq_arb_pkg;

    // Arbiter handshake states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CLR  = 2'd2
    } irq_arb_state_e;

    localparam int IRQ_ARB_NB_IRQ = 32;
    localparam int IRQ_ARB_ID_W   = 5;

    // True when n is a nonzero power of two not above the supported line count
    function automatic bit irq_arb_nb_ok(input int n);
        return (n > 0) && (n <= IRQ_ARB_NB_IRQ) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/apb_irq_arbiter_if.sv
// Interrupt pending-vector / core handshake bundle between the event unit,
// the arbiter and the core. The arbiter uses the slave view; whoever drives
// the pending vector and acknowledges uses the master view.
interface apb_irq_arbiter_if
    import irq_arb_pkg::*;
#(
    parameter int NB_IRQ = IRQ_ARB_NB_IRQ
) ();
    localparam int ID_W = $clog2(NB_IRQ);

    logic [NB_IRQ-1:0] irq_i;
    logic              irq_en_i;
    logic              irq_req_o;
    logic [ID_W-1:0]   irq_id_o;
    logic              irq_ack_i;
    logic [ID_W-1:0]   irq_ack_id_i;
    logic [NB_IRQ-1:0] irq_clr_o;
    logic              irq_busy_o;

    modport slave (
        input  irq_i,
        input  irq_en_i,
        input  irq_ack_i,
        input  irq_ack_id_i,
        output irq_req_o,
        output irq_id_o,
        output irq_clr_o,
        output irq_busy_o
    );

    modport master (
        output irq_i,
        output irq_en_i,
        output irq_ack_i,
        output irq_ack_id_i,
        input  irq_req_o,
        input  irq_id_o,
        input  irq_clr_o,
        input  irq_busy_o
    );

endinterface

// File: rtl/apb_irq_arbiter_prio_enc.sv
// Rotating-priority find-first-one encoder. The vector is rotated so that
// bit ptr lands at position 0, the lowest set bit is found, and the index is
// rotated back. With ptr = 0 this is a plain lowest-index-wins encoder.
module irq_prio_enc #(
    parameter int NB_IRQ = 32,
    parameter int ID_W   = $clog2(NB_IRQ)
) (
    input  logic [NB_IRQ-1:0] vec,
    input  logic [ID_W-1:0]   ptr,
    output logic              valid,
    output logic [ID_W-1:0]   id
);

    logic [NB_IRQ-1:0] vec_rot;
    logic [ID_W-1:0]   rot_idx;

    // Rotate right by ptr; index arithmetic wraps because NB_IRQ is 2**ID_W
    always_comb begin
        logic [ID_W-1:0] src;
        vec_rot = '0;
        for (int i = 0; i < NB_IRQ; i++) begin
            src        = ID_W'(i) + ptr;
            vec_rot[i] = vec[src];
        end
    end

    // Lowest set bit of the rotated vector; scanning downward lets the
    // smallest index overwrite any higher hit
    always_comb begin
        rot_idx = '0;
        for (int i = NB_IRQ - 1; i >= 0; i--) begin
            if (vec_rot[i]) begin
                rot_idx = ID_W'(i);
            end
        end
    end

    assign id    = rot_idx + ptr;
    assign valid = |vec;

endmodule

// File: rtl/apb_irq_arbiter.sv
// Interrupt arbiter: picks one pending line, presents it to the core as a
// held request/ID pair, and on matching acknowledge pulses a one-hot clear
// back toward the pending register.
// Optional feature: define IRQ_ARB_ROUND_ROBIN_EN for rotating priority
// (pointer moves past each acknowledged line); default is fixed priority,
// lowest index first.
module apb_irq_arbiter
    import irq_arb_pkg::*;
#(
    parameter int NB_IRQ = IRQ_ARB_NB_IRQ,
    parameter int ID_W   = $clog2(NB_IRQ)
) (
    input logic              HCLK,
    input logic              HRESETn,
    apb_irq_arbiter_if.slave bus
);

    irq_arb_state_e    state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   ptr_q;
    logic              req_q, req_d;
    logic [NB_IRQ-1:0] clr_q, clr_d;
    logic              busy_q, busy_d;
    logic              enter_clr;

    logic [NB_IRQ-1:0] irq_vec;
    logic              enc_valid;
    logic [ID_W-1:0]   enc_id;
    logic              ack_hit;

    assign irq_vec = bus.irq_i;
    assign ack_hit = bus.irq_ack_i && (bus.irq_ack_id_i == id_q);

    irq_prio_enc #(
        .NB_IRQ (NB_IRQ),
        .ID_W   (ID_W)
    ) u_prio_enc (
        .vec   (irq_vec),
        .ptr   (ptr_q),
        .valid (enc_valid),
        .id    (enc_id)
    );

    // Next state and next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        req_d     = 1'b0;
        clr_d     = '0;
        enter_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.irq_en_i && enc_valid) begin
                    state_d = REQ;
                    id_d    = enc_id;
                    req_d   = 1'b1;
                end
            end
            REQ: begin
                // Ack beats a same-cycle withdraw; enable is not consulted here
                if (ack_hit) begin
                    state_d   = CLR;
                    clr_d     = NB_IRQ'(1) << id_q;
                    enter_clr = 1'b1;
                end else if (!irq_vec[id_q]) begin
                    state_d = IDLE;
                end else begin
                    req_d = 1'b1;
                end
            end
            CLR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, latched ID and output registers
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            id_q    <= '0;
            req_q   <= 1'b0;
            clr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            req_q   <= req_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
        end
    end

`ifdef IRQ_ARB_ROUND_ROBIN_EN
    // Priority pointer moves just past the line being cleared
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            ptr_q <= '0;
        end else if (enter_clr) begin
            ptr_q <= id_q + ID_W'(1);
        end
    end
`else
    logic unused_enter_clr;
    assign unused_enter_clr = enter_clr;
    assign ptr_q            = '0;
`endif

    assign bus.irq_req_o  = req_q;
    assign bus.irq_id_o   = id_q;
    assign bus.irq_clr_o  = clr_q;
    assign bus.irq_busy_o = busy_q;

endmodule

// File: tb/tb_apb_irq_arbiter.sv
// Bench for apb_irq_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural
// model of the arbitration rules.
module tb_apb_irq_arbiter;

    logic clk;
    logic rstn;
    int   tests = 0;
    int   fails = 0;

    apb_irq_arbiter_if #(.NB_IRQ(32)) bus ();

    apb_irq_arbiter dut (
        .HCLK    (clk),
        .HRESETn (rstn),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_pend;
    bit          m_clearing;
    int          m_id;
    int          m_ptr;
    logic        exp_req;
    logic [4:0]  exp_id;
    logic [31:0] exp_clr;
    logic        exp_busy;

    function automatic int winner(input logic [31:0] v, input int p);
        for (int k = 0; k < 32; k++) begin
            int j;
            j = (p + k) % 32;
            if (v[j]) return j;
        end
        return 0;
    endfunction

    // Inputs only change 2 units after a falling edge, so at the falling edge
    // they are exactly what the preceding rising edge sampled.
    initial begin
        m_pend = 0; m_clearing = 0; m_id = 0; m_ptr = 0;
        exp_req = 0; exp_id = 0; exp_clr = 0; exp_busy = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                m_pend = 0; m_clearing = 0; m_id = 0; m_ptr = 0;
            end else if (m_clearing) begin
                m_clearing = 0;
            end else if (m_pend) begin
                if (bus.irq_ack_i && int'(bus.irq_ack_id_i) == m_id) begin
                    m_pend     = 0;
                    m_clearing = 1;
`ifdef IRQ_ARB_ROUND_ROBIN_EN
                    m_ptr = (m_id + 1) % 32;
`endif
                end else if (!bus.irq_i[m_id]) begin
                    m_pend = 0;
                end
            end else if (bus.irq_en_i && bus.irq_i != 0) begin
                m_id   = winner(bus.irq_i, m_ptr);
                m_pend = 1;
            end
            exp_req  = m_pend;
            exp_id   = 5'(m_id);
            exp_clr  = m_clearing ? (32'd1 << m_id) : 32'd0;
            exp_busy = m_pend || m_clearing;
            check("cyc_req",  32'(bus.irq_req_o),  32'(exp_req));
            check("cyc_id",   32'(bus.irq_id_o),   32'(exp_id));
            check("cyc_clr",  bus.irq_clr_o,       exp_clr);
            check("cyc_busy", 32'(bus.irq_busy_o), 32'(exp_busy));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_req(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            if (bus.irq_req_o === 1'b1) seen = 1;
        end
        check({name, "_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.irq_ack_i = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic check_idle_outs(input string name);
        check({name, "_req"},  32'(bus.irq_req_o),  32'd0);
        check({name, "_id"},   32'(bus.irq_id_o),   32'd0);
        check({name, "_clr"},  bus.irq_clr_o,       32'd0);
        check({name, "_busy"}, 32'(bus.irq_busy_o), 32'd0);
    endtask

    int rr_exp [4];

    initial begin
`ifdef IRQ_ARB_ROUND_ROBIN_EN
        rr_exp = '{0, 31, 0, 31};
`else
        rr_exp = '{0, 0, 0, 0};
`endif
        // Reset held with every line pending
        rstn             = 1'b0;
        bus.irq_i        = 32'hFFFF_FFFF;
        bus.irq_en_i     = 1'b1;
        bus.irq_ack_i    = 1'b0;
        bus.irq_ack_id_i = 5'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle_outs("rst");
        end
        rstn = 1'b1;
        tick();
        check("rel_req", 32'(bus.irq_req_o), 32'd1);
        check("rel_id",  32'(bus.irq_id_o),  32'd0);

        // Lines 4 and 8 pending
        bus.irq_i = 32'h0000_0000;
        do_reset();
        bus.irq_i = 32'h0000_0110;
        tick();
        check("fx_req", 32'(bus.irq_req_o), 32'd1);
        check("fx_id",  32'(bus.irq_id_o),  32'd4);
        bus.irq_ack_i = 1'b1; bus.irq_ack_id_i = 5'd4;
        tick();
        bus.irq_ack_i = 1'b0;
        check("fx_clr",     bus.irq_clr_o,      32'h0000_0010);
        check("fx_clr_req", 32'(bus.irq_req_o), 32'd0);
        bus.irq_i = 32'h0000_0100;
        tick();
        check("fx_clr_once", bus.irq_clr_o, 32'h0);
        tick();
        check("fx_next_id", 32'(bus.irq_id_o),  32'd8);
        check("fx_next_rq", 32'(bus.irq_req_o), 32'd1);
        bus.irq_i = 32'h0;
        tick();

        // Lines 0 and 31 held, each request acknowledged
        do_reset();
        bus.irq_i = 32'h8000_0001;
        for (int n = 0; n < 4; n++) begin
            wait_req("rr");
            check("rr_id", 32'(bus.irq_id_o), 32'(rr_exp[n]));
            bus.irq_ack_i = 1'b1; bus.irq_ack_id_i = 5'(rr_exp[n]);
            tick();
            bus.irq_ack_i = 1'b0;
            check("rr_clr", bus.irq_clr_o, 32'd1 << rr_exp[n]);
            tick();
        end
        bus.irq_i = 32'h0;
        tick();

        // Ack and withdraw in the same cycle, then withdraw alone
        do_reset();
        bus.irq_i = 32'h0000_0008;
        tick();
        check("aw_id", 32'(bus.irq_id_o), 32'd3);
        bus.irq_i = 32'h0; bus.irq_ack_i = 1'b1; bus.irq_ack_id_i = 5'd3;
        tick();
        bus.irq_ack_i = 1'b0;
        check("aw_clr", bus.irq_clr_o, 32'h0000_0008);
        tick(); tick();
        bus.irq_i = 32'h0000_0008;
        tick();
        check("wd_req1", 32'(bus.irq_req_o), 32'd1);
        bus.irq_i = 32'h0;
        tick();
        check("wd_req0", 32'(bus.irq_req_o), 32'd0);
        check("wd_clr",  bus.irq_clr_o,      32'h0);
        tick();
        check("wd_clr2", bus.irq_clr_o, 32'h0);

        // Mismatched ack ignored; enable gates new requests
        bus.irq_i = 32'h0000_0020;
        tick();
        check("mm_id", 32'(bus.irq_id_o), 32'd5);
        bus.irq_ack_i = 1'b1; bus.irq_ack_id_i = 5'd6;
        tick();
        bus.irq_ack_i = 1'b0;
        check("mm_req", 32'(bus.irq_req_o), 32'd1);
        check("mm_id2", 32'(bus.irq_id_o),  32'd5);
        check("mm_clr", bus.irq_clr_o,      32'h0);
        bus.irq_i = 32'h0;
        tick();
        bus.irq_en_i = 1'b0; bus.irq_i = 32'h1;
        tick(); tick();
        check("en_off_req", 32'(bus.irq_req_o), 32'd0);
        bus.irq_en_i = 1'b1;
        tick();
        check("en_on_req", 32'(bus.irq_req_o), 32'd1);
        check("en_on_id",  32'(bus.irq_id_o),  32'd0);

        // Reset during an outstanding request; pointer must return to 0
        rstn = 1'b0;
        bus.irq_i = 32'h8000_0001;
        tick();
        check_idle_outs("midrst");
        rstn = 1'b1;
        tick();
        check("midrst_id", 32'(bus.irq_id_o), 32'd0);
        bus.irq_ack_i = 1'b1; bus.irq_ack_id_i = 5'd0;
        tick();
        bus.irq_ack_i = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(99) < 25) begin
                case ($urandom_range(3))
                    0: bus.irq_i = 32'd1 << $urandom_range(31);
                    1: bus.irq_i = $urandom & $urandom & $urandom;
                    2: bus.irq_i = 32'h0;
                    default: bus.irq_i = $urandom;
                endcase
            end
            if (exp_req && $urandom_range(9) == 0) bus.irq_i[exp_id] = 1'b0;
            bus.irq_en_i = ($urandom_range(9) != 0);
            bus.irq_ack_i = 1'b0;
            if (exp_req && $urandom_range(99) < 35) begin
                bus.irq_ack_i    = 1'b1;
                bus.irq_ack_id_i = ($urandom_range(4) == 0) ? 5'($urandom_range(31)) : exp_id;
            end else if ($urandom_range(19) == 0) begin
                bus.irq_ack_i    = 1'b1;
                bus.irq_ack_id_i = 5'($urandom_range(31));
            end
            rstn = ($urandom_range(199) != 0);
            tick();
        end
        rstn = 1'b1;
        bus.irq_ack_i = 1'b0;
        bus.irq_i = 32'h0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
